vt52_input_arbiter: RTL and testbench



---
 rtl/vt52_input_arbiter.sv | 152 +++++++++++++++
 tb/tb_vt52_input_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vt52_input_arbiter.sv
// rtl/vt52_input_arbiter.sv - N-channel input FIFOs drained by an arbiter into one tagged output stream
// Build option: define VT52_ARB_FIXED_PRIO_EN for fixed priority (lowest channel wins); default is round-robin
module vt52_input_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SRC_BITS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SRC_BITS-1:0]      out_src,
  output logic [NUM_CH-1:0]        ch_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [7:0]        wd_cnt [NUM_CH];

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              stage_free;
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;

`ifndef VT52_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  rr;
`endif

  // A full FIFO never accepts, even when it is being popped in the same cycle
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready[k] = (count[k] != FULL_CNT) & rst_n;
    end
  end

  assign push       = in_valid & in_ready;
  assign stage_free = !out_valid | out_ready;

  // Pick the first non-empty FIFO, searching from rr (or from channel 0 in fixed-priority builds)
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef VT52_ARB_FIXED_PRIO_EN
      if (!grant_found && count[i] != '0) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
`else
      if (!grant_found && count[(int'(rr) + i) % NUM_CH] != '0) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((int'(rr) + i) % NUM_CH);
      end
`endif
    end
  end

  // Only the granted FIFO pops, and only when the output register can take its head
  always_comb begin
    pop = '0;
    if (stage_free && grant_found) begin
      pop[grant_idx] = 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers and counts define validity
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) begin
        mem[k][wr_ptr[k]] <= in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves the count alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        if (push[k] && !pop[k]) begin
          count[k] <= count[k] + CNT_W'(1);
        end else if (!push[k] && pop[k]) begin
          count[k] <= count[k] - CNT_W'(1);
        end
      end
    end
  end

  // Output register: load the granted head, or drop valid when nothing is waiting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
`ifndef VT52_ARB_FIXED_PRIO_EN
      rr        <= '0;
`endif
    end else if (stage_free) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= mem[grant_idx][rd_ptr[grant_idx]];
        out_src   <= SRC_BITS'(grant_idx);
`ifndef VT52_ARB_FIXED_PRIO_EN
        rr        <= (grant_idx == LAST_CH) ? '0 : grant_idx + IDX_W'(1);
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Stall watchdog: count consecutive blocked cycles, latch the LED flag on the 255th
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_overflow <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        wd_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (in_valid[k] && !in_ready[k]) begin
          if (wd_cnt[k] != 8'hFF) wd_cnt[k] <= wd_cnt[k] + 8'd1;
          if (wd_cnt[k] == 8'hFE) ch_overflow[k] <= 1'b1;
        end else begin
          wd_cnt[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vt52_input_arbiter.sv
// tb/tb_vt52_input_arbiter.sv - directed self-checking bench for vt52_input_arbiter
module tb_vt52_input_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_src;
  logic [1:0]  ch_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] got_d [$];
  logic       got_s [$];
  int         got_t [$];

  vt52_input_arbiter #(
    .NUM_CH(2), .DATA_W(8), .FIFO_DEPTH(4), .SRC_BITS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_src(out_src), .ch_overflow(ch_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    got_d.delete();
    got_s.delete();
    got_t.delete();
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_d.push_back(out_data);
        got_s.push_back(out_src[0]);
        got_t.push_back(cyc);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 2'b11;
    in_data   = 16'hAAAA;
    out_ready = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_checks++;
    if (out_src !== 1'b0) begin n_fail++; $display("FAIL reset_out_src: got %b expected 0", out_src); end
    n_checks++;
    if (ch_overflow !== 2'b00) begin n_fail++; $display("FAIL reset_overflow: got %b expected 00", ch_overflow); end
    n_checks++;
    if (in_ready !== 2'b00) begin n_fail++; $display("FAIL reset_in_ready_low: got %b expected 00", in_ready); end
    in_valid = 2'b00;
    rst_n    = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 2'b11) begin n_fail++; $display("FAIL reset_in_ready_after: got %b expected 11", in_ready); end
  endtask

  task automatic test_single_push();
    do_reset();
    in_valid  = 2'b01;
    in_data   = 16'h0041;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 2'b11) begin n_fail++; $display("FAIL single_in_ready: got %b expected 11", in_ready); end
    tick();
    in_valid = 2'b00;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_cycle1_valid: got %b expected 0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h41 || out_src !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cycle2: got valid=%b data=%h src=%b expected valid=1 data=41 src=0", out_valid, out_data, out_src);
    end
    n_checks++;
    if (in_ready !== 2'b11) begin n_fail++; $display("FAIL single_in_ready2: got %b expected 11", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_cycle3_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4];
    logic       exp_s [4];
`ifdef VT52_ARB_FIXED_PRIO_EN
    exp_d = '{8'h10, 8'h11, 8'h20, 8'h21};
    exp_s = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    clear_log();
    in_valid = 2'b11;
    in_data  = 16'h2010;
    tick();
    in_data  = 16'h2111;
    tick();
    in_valid  = 2'b00;
    out_ready = 1'b1;
    drain(8);
    n_checks++;
    if (got_d.size() !== 4) begin n_fail++; $display("FAIL rr_count: got %0d expected 4", got_d.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %h/%b expected %h/%b", i,
                 (i < got_d.size()) ? got_d[i] : 8'hxx, (i < got_s.size()) ? got_s[i] : 1'bx, exp_d[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit accepted;
    do_reset();
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 2'b10;
      in_data  = {8'(8'h51 + i), 8'h00};
      tick();
    end
    in_data = 16'h5600;
    n_checks++;
    if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", in_ready[1]); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h51 || out_src !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stage_head: got valid=%b data=%h src=%b expected 1/51/1", out_valid, out_data, out_src);
    end
    tick(); tick();
    n_checks++;
    if (in_ready[1] !== 1'b0 || out_data !== 8'h51) begin
      n_fail++;
      $display("FAIL bp_held: got ready=%b data=%h expected ready=0 data=51", in_ready[1], out_data);
    end
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid === 1'b1) begin
        got_d.push_back(out_data);
        got_s.push_back(out_src[0]);
      end
      if (in_valid[1] && in_ready[1] === 1'b1) accepted = 1'b1;
      tick();
      if (accepted) in_valid = 2'b00;
    end
    n_checks++;
    if (accepted !== 1'b1) begin n_fail++; $display("FAIL bp_fifth_accepted: got %b expected 1", accepted); end
    n_checks++;
    if (got_d.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got_d.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= got_d.size() || got_d[i] !== 8'(8'h51 + i) || got_s[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, 8'(8'h51 + i));
      end
    end
  endtask

  task automatic test_output_hold();
    do_reset();
    clear_log();
    out_ready = 1'b0;
    in_valid  = 2'b01;
    in_data   = 16'h0061;
    tick();
    in_valid = 2'b00;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        in_valid = 2'b01;
        in_data  = {8'h00, 8'(8'h62 + i)};
      end else begin
        in_valid = 2'b00;
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h61 || out_src !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got valid=%b data=%h src=%b expected 1/61/0", i, out_valid, out_data, out_src);
      end
    end
    out_ready = 1'b1;
    drain(10);
    n_checks++;
    if (got_d.size() !== 5) begin n_fail++; $display("FAIL hold_count: got %0d expected 5", got_d.size()); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got_d.size() || got_d[i] !== 8'(8'h61 + i)) begin
        n_fail++;
        $display("FAIL hold_order[%0d]: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, 8'(8'h61 + i));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0) ? 2'b01 : 2'b10;
      in_data  = {8'(8'h80 + i), 8'(8'h80 + i)};
      drain(1);
    end
    in_valid = 2'b00;
    drain(6);
    n_checks++;
    if (got_d.size() !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got_d.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_d.size() || got_d[i] !== 8'(8'h80 + i) || got_s[i] !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: got %h/%b expected %h/%b", i,
                 (i < got_d.size()) ? got_d[i] : 8'hxx, (i < got_s.size()) ? got_s[i] : 1'bx, 8'(8'h80 + i), 1'(i % 2));
      end
    end
    n_checks++;
    if (got_t.size() != 8 || (got_t[7] - got_t[0]) != 7) begin
      n_fail++;
      $display("FAIL b2b_throughput: got span %0d expected 7", (got_t.size() == 8) ? got_t[7] - got_t[0] : -1);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 2'b01;
    in_data   = 16'h0090;
    repeat (5) tick();
    n_checks++;
    if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL wd_full: got %b expected 0", in_ready[0]); end
    repeat (254) tick();
    n_checks++;
    if (ch_overflow[0] !== 1'b0) begin n_fail++; $display("FAIL wd_254: got %b expected 0", ch_overflow[0]); end
    tick();
    n_checks++;
    if (ch_overflow[0] !== 1'b1) begin n_fail++; $display("FAIL wd_255: got %b expected 1", ch_overflow[0]); end
    in_valid  = 2'b00;
    out_ready = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (ch_overflow !== 2'b01) begin n_fail++; $display("FAIL wd_sticky: got %b expected 01", ch_overflow); end
    do_reset();
    n_checks++;
    if (ch_overflow !== 2'b00) begin n_fail++; $display("FAIL wd_reset_clear: got %b expected 00", ch_overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 2'b01;
      in_data  = {8'h00, 8'(8'h71 + i)};
      tick();
    end
    in_valid = 2'b00;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h71) begin
      n_fail++;
      $display("FAIL mid_preload: got valid=%b data=%h expected 1/71", out_valid, out_data);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_after_reset: got valid=%b data=%h ready=%b expected 0/00/11", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_fifo_empty: got %b expected 0", out_valid); end
    in_valid = 2'b10;
    in_data  = 16'h7A00;
    tick();
    in_valid = 2'b00;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1: got %b expected 0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h7A || out_src !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_lat2: got valid=%b data=%h src=%b expected 1/7a/1", out_valid, out_data, out_src);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_round_robin();
    test_backpressure();
    test_output_hold();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
